// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding common to transmitter and receiver,
// default bit period and frame geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    localparam int UART_CLKS_PER_BIT_DEFAULT = 434;
    localparam int UART_DATA_BITS            = 8;
    localparam int UART_COUNT_W              = 16;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, flags the last
// cycle of a bit. Clear has priority over enable.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    output logic [UART_COUNT_W-1:0] count,
    output logic                    last
);

    localparam logic [UART_COUNT_W-1:0] LAST_VAL = UART_COUNT_W'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + UART_COUNT_W'(1);
        end
    end

    assign last = (count == LAST_VAL);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per accepted request, LSB first, each bit
// CLKS_PER_BIT cycles; requests while busy are dropped.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tx_start,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    output logic                      tx,
    output logic                      tx_busy,
    output logic                      tx_done
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_t               state;
    uart_state_t               state_nxt;
    logic [2:0]                bit_index;
    logic [2:0]                bit_index_nxt;
    logic [UART_DATA_BITS-1:0] shreg;
    logic [UART_DATA_BITS-1:0] shreg_nxt;
    logic [UART_COUNT_W-1:0]   clk_count;
    logic                      last;
    logic                      cnt_clr;
    logic                      cnt_en;
    logic                      tx_nxt;
    logic                      busy_nxt;
    logic                      done_nxt;
    logic                      unused_count;

    // Counter is held at zero in IDLE so every frame starts from a clean bit.
    assign cnt_clr = (state == IDLE) || last;
    assign cnt_en  = (state != IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (clk_count),
        .last  (last)
    );

    assign unused_count = ^clk_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tx_start) state_nxt = START;
            START:   if (last) state_nxt = DATA;
            DATA:    if (last && (bit_index == LAST_BIT)) state_nxt = STOP;
            STOP:    if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bit_index_nxt = bit_index;
        shreg_nxt     = shreg;
        case (state)
            IDLE: begin
                if (tx_start) shreg_nxt = tx_data;
            end
            START: begin
                if (last) bit_index_nxt = 3'd0;
            end
            DATA: begin
                if (last) begin
                    shreg_nxt     = shreg >> 1;
                    bit_index_nxt = bit_index + 3'd1;
                end
            end
            default: begin
                bit_index_nxt = bit_index;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_index <= 3'd0;
            shreg     <= '0;
        end else begin
            bit_index <= bit_index_nxt;
            shreg     <= shreg_nxt;
        end
    end

    // Outputs are computed from the next state so the line settles one cycle
    // after acceptance and stays glitch-free from a flop.
    always_comb begin
        tx_nxt   = 1'b1;
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == STOP) && last;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx      <= tx_nxt;
            tx_busy <= busy_nxt;
            tx_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: randomized and directed requests, frames decoded from the
// serial line and compared against a queue of expected bytes and start times.
module tb_uart_tx;

    localparam int N4 = 4;
    localparam int NDEF = 434;
    localparam int FRAME = 10 * N4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx4, busy4, done4;
    logic       start_d = 1'b0;
    logic [7:0] data_d = 8'h00;
    logic       tx_d, busy_d, done_d;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(N4)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
        .tx(tx4), .tx_busy(busy4), .tx_done(done4)
    );

    uart_tx dut_def (
        .clk(clk), .rst(rst), .tx_start(start_d), .tx_data(data_d),
        .tx(tx_d), .tx_busy(busy_d), .tx_done(done_d)
    );

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    logic rst_q = 1'b1;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    endfunction

    // Reference model: a request is taken only if the line is free, and the
    // line is free again 10 bit-times plus one cycle after the last accept.
    typedef struct {
        logic [7:0] data;
        int         t;
    } exp_t;
    exp_t exp_q[$];
    int   next_free = 0;

    task automatic step(input logic s, input logic [7:0] d, input logic r);
        rst = r;
        tx_start = s;
        tx_data = d;
        if (r) begin
            exp_q.delete();
            next_free = cyc + 1;
        end else if (s && cyc >= next_free) begin
            exp_q.push_back('{data: d, t: cyc});
            next_free = cyc + FRAME + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    // Monitor: recovers frames from the line and checks them against the queue.
    logic       in_frame = 1'b0;
    logic       wait_done = 1'b0;
    logic       busy_bad;
    int         fcyc;
    int         k;
    logic       smp[FRAME];
    logic [7:0] got;
    logic       glitch;
    exp_t       e;

    always @(negedge clk) begin
        if (rst_q) begin
            chk("reset_idle", {29'd0, tx4, busy4, done4}, 32'b100);
            in_frame  = 1'b0;
            wait_done = 1'b0;
        end else begin
            if (wait_done) begin
                wait_done = 1'b0;
                chk("done_pulse", {31'd0, done4}, 32'd1);
                chk("busy_drop", {31'd0, busy4}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("frame_expected", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_data", {24'd0, got}, {24'd0, e.data});
                    chk("frame_start_cycle", fcyc, e.t + 1);
                end
            end else if (done4) begin
                chk("stray_done", {31'd0, done4}, 32'd0);
            end
            if (in_frame) begin
                if (!busy4) busy_bad = 1'b1;
                smp[k] = tx4;
                k++;
                if (k == FRAME) begin
                    in_frame  = 1'b0;
                    wait_done = 1'b1;
                    glitch = 1'b0;
                    for (int b = 0; b < 10; b++)
                        for (int j = 1; j < N4; j++)
                            if (smp[b*N4+j] !== smp[b*N4]) glitch = 1'b1;
                    for (int b = 0; b < 8; b++) got[b] = smp[(b+1)*N4];
                    chk("bit_width_stable", {31'd0, glitch}, 32'd0);
                    chk("start_stop_bits", {30'd0, smp[0], smp[FRAME-1]}, 32'b01);
                    chk("busy_in_frame", {31'd0, busy_bad}, 32'd0);
                end
            end else if (!wait_done && tx4 === 1'b0) begin
                in_frame = 1'b1;
                fcyc     = cyc;
                smp[0]   = 1'b0;
                k        = 1;
                busy_bad = !busy4;
            end
        end
    end

    int   t0;
    int   ne;
    int   done_at;
    logic prev;
    int   edges[10];

    initial begin
        @(posedge clk);
        #1;
        // Reset held with a pending request; the request is taken on release.
        for (int i = 0; i < 3; i++) step(1'b1, 8'h11, 1'b1);
        step(1'b1, 8'hA5, 1'b0);
        idle(FRAME + 4);

        // Requests during a frame are dropped.
        step(1'b1, 8'h3C, 1'b0);
        for (int i = 1; i <= 44; i++)
            step((i == 10 || i == 40), (i == 10 || i == 40) ? 8'hFF : 8'h00, 1'b0);
        idle(4);

        // Held request re-triggers in each done cycle.
        step(1'b1, 8'h00, 1'b0);
        for (int i = 1; i <= 2 * (FRAME + 1); i++) step(1'b1, 8'hFF, 1'b0);
        idle(FRAME + 4);

        // Reset during DATA aborts the frame; next request is clean.
        step(1'b1, 8'h5A, 1'b0);
        idle(16);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h81, 1'b0);
        idle(FRAME + 4);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 5) == 0, 8'($urandom), 1'b0);
        idle(FRAME + 4);

        chk("queue_drained", exp_q.size(), 32'd0);
        chk("no_open_frame", {30'd0, in_frame, wait_done}, 32'd0);

        // Default bit period: every bit boundary of 0x55 is a line edge.
        t0 = cyc;
        start_d = 1'b1;
        data_d  = 8'h55;
        @(posedge clk);
        #1;
        start_d = 1'b0;
        data_d  = 8'h00;
        prev = 1'b1;
        ne = 0;
        done_at = -1;
        for (int c = 0; c < 10 * NDEF + 20; c++) begin
            if (tx_d !== prev) begin
                if (ne < 10) edges[ne] = cyc;
                ne++;
                prev = tx_d;
            end
            if (done_d === 1'b1 && done_at < 0) done_at = cyc;
            @(posedge clk);
            #1;
        end
        chk("def_edge_count", ne, 32'd10);
        for (int b = 0; b < 10; b++)
            if (b < ne) chk("def_bit_edge", edges[b], t0 + 1 + b * NDEF);
        chk("def_done_cycle", done_at, t0 + 10 * NDEF + 1);
        chk("def_idle_line", {31'd0, tx_d}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
